// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types and constants: fetch payload, queue sizing, reset pc.
package fetch_queue_pkg;

    localparam int unsigned PC_W    = 64;
    localparam int unsigned INSTR_W = 32;

    // Reset pc shared with the pc generator.
    localparam logic [PC_W-1:0] FETCHQ_RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] raw_instr;
    } fetch_data_t;

    // Decode sizes its own logic from these.
    localparam int unsigned FETCHQ_DEPTH = 4;
    localparam int unsigned FETCHQ_PTR_W = $clog2(FETCHQ_DEPTH);
    localparam int unsigned FETCHQ_CNT_W = $clog2(FETCHQ_DEPTH + 1);

    typedef logic [FETCHQ_PTR_W-1:0] fetch_queue_ptr_t;
    typedef logic [FETCHQ_CNT_W-1:0] fetch_queue_count_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x fetch_data_t register array: one synchronous write port, one async read port.
module fetch_queue_mem
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FETCHQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_data_t              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_data_t              rdata
);

    fetch_data_t entries [DEPTH];

    // Contents need no reset; occupancy control in the parent gates every read.
    always_ff @(posedge clk) begin
        if (we) begin
            entries[waddr] <= wdata;
        end
    end

    assign rdata = entries[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction buffer with stall absorption, redirect flush and bubble output.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned      DEPTH    = FETCHQ_DEPTH,
    parameter logic [PC_W-1:0]  RESET_PC = FETCHQ_RESET_PC
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  fetch_data_t                  in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output fetch_data_t                  out_data,
    input  logic                         stall,
    input  logic                         stallM,
    input  logic                         jump,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two >= 2");
    end

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PC_W-1:0]  last_pc;
    fetch_data_t      head;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);

    assign push = in_valid & in_ready & ~jump;
    assign pop  = out_valid & out_ready & ~stall & ~stallM & ~jump;

    fetch_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // Bubble keeps the pc of the last entry handed to decode.
    always_comb begin
        out_data.pc        = last_pc;
        out_data.raw_instr = '0;
        if (out_valid) begin
            out_data = head;
        end
    end

    // Flush wins over push/pop; last_pc survives it so the bubble shows the pre-redirect pc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            last_pc <= RESET_PC;
        end else if (jump) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                last_pc <= head.pc;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule
